// File: rtl/mavg_pkg.sv
// Shared types and helpers for the TDM moving-average filter.
package mavg_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    function automatic int acc_width(input int w, input int log2n_max);
        return w + log2n_max;
    endfunction

    function automatic int unsigned clamp_log2n(input int unsigned v, input int unsigned vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/mavg_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable, no reset.
module mavg_sdp_ram #(
    parameter int DW    = 10,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/mavg_tdm_filter.sv
// Multi-channel TDM moving-average filter using a running sum over a circular RAM buffer.
// Define MAVG_ROUND_EN for round-half-up output instead of floor.
//   state | meaning
//   CLEAR | sweeping RAM to zero, accumulators/pointers cleared, no traffic
//   RUN   | accepting samples, 3-stage pipeline (accept/read, update/write, output)
module mavg_tdm_filter
    import mavg_pkg::*;
#(
    parameter int W         = 10,
    parameter int LOG2N_MAX = 5,
    parameter int CH        = 4,
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1,
    localparam int LW       = $clog2(LOG2N_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [LW-1:0]       cfg_log2n,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_ch,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_ch,
    output logic signed [W-1:0] out_data
);

    localparam int NMAX  = 1 << LOG2N_MAX;
    localparam int DEPTH = CH * NMAX;
    localparam int AW    = CW + LOG2N_MAX;
    localparam int ACW   = acc_width(W, LOG2N_MAX);
    localparam int ACW1  = ACW + 1;
    localparam int CLRW  = $clog2(DEPTH + 1);

    state_t                r_state;
    logic [LW-1:0]         r_log2n;
    logic [CLRW-1:0]       r_clr_cnt;
    logic signed [ACW-1:0] r_acc [CH];
    logic [LOG2N_MAX-1:0]  r_wp  [CH];

    logic                  r_s1_valid;
    logic [CW-1:0]         r_s1_ch;
    logic signed [W-1:0]   r_s1_x;
    logic [LOG2N_MAX-1:0]  r_s1_wptr;
    logic                  r_s1_fwd;
    logic signed [W-1:0]   r_s1_fwd_data;

    logic                  w_stall, w_ch_ok, w_accept, w_fwd_hit, w_ram_we, w_ram_re;
    logic [LOG2N_MAX-1:0]  w_wp_cur, w_rd_ptr;
    logic [AW-1:0]         w_rd_addr, w_s1_addr, w_ram_waddr;
    logic [W-1:0]          w_ram_wdata, w_ram_rdata;
    logic signed [W-1:0]   w_oldest, w_avg;
    logic signed [ACW-1:0] w_acc_new;

    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = (r_state == RUN) && !w_stall;
    assign busy      = (r_state == CLEAR);
    assign w_ch_ok   = (32'(in_ch) < CH);
    assign w_accept  = in_valid && in_ready && !cfg_load && w_ch_ok;

    // Pointer wraps at N_MAX, so N == N_MAX reads back the slot about to be overwritten.
    assign w_wp_cur  = r_wp[in_ch];
    assign w_rd_ptr  = w_wp_cur - LOG2N_MAX'(32'd1 << r_log2n);
    assign w_rd_addr = {in_ch, w_rd_ptr};
    assign w_s1_addr = {r_s1_ch, r_s1_wptr};
    assign w_fwd_hit = r_s1_valid && (w_rd_addr == w_s1_addr);

    assign w_oldest  = r_s1_fwd ? r_s1_fwd_data : $signed(w_ram_rdata);
    assign w_acc_new = r_acc[r_s1_ch] + ACW'(r_s1_x) - ACW'(w_oldest);

`ifdef MAVG_ROUND_EN
    logic signed [ACW1-1:0] w_rnd, w_acc_rnd;
    assign w_rnd     = (r_log2n != '0) ? ACW1'(1 << (r_log2n - 1'b1)) : '0;
    assign w_acc_rnd = ACW1'(w_acc_new) + w_rnd;
    assign w_avg     = W'(w_acc_rnd >>> r_log2n);
`else
    assign w_avg     = W'(w_acc_new >>> r_log2n);
`endif

    assign w_ram_we    = (r_state == CLEAR) || (r_s1_valid && !w_stall);
    assign w_ram_waddr = (r_state == CLEAR) ? AW'(r_clr_cnt) : w_s1_addr;
    assign w_ram_wdata = (r_state == CLEAR) ? '0 : r_s1_x;
    assign w_ram_re    = !w_stall;

    mavg_sdp_ram #(
        .DW    (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_state    <= CLEAR;
            r_clr_cnt  <= CLRW'(DEPTH - 1);
            r_s1_valid <= 1'b0;
            out_valid  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_acc[i] <= '0;
                r_wp[i]  <= '0;
            end
            if (rst) begin
                r_log2n  <= LW'(LOG2N_MAX);
                out_data <= '0;
                out_ch   <= '0;
            end else begin
                r_log2n  <= LW'(clamp_log2n(32'(cfg_log2n), LOG2N_MAX));
            end
        end else if (r_state == CLEAR) begin
            r_s1_valid <= 1'b0;
            out_valid  <= 1'b0;
            if (r_clr_cnt == '0) r_state <= RUN;
            else                 r_clr_cnt <= r_clr_cnt - 1'b1;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ch       <= in_ch;
                r_s1_x        <= in_data;
                r_s1_wptr     <= w_wp_cur;
                r_s1_fwd      <= w_fwd_hit;
                r_s1_fwd_data <= r_s1_x;
                r_wp[in_ch]   <= w_wp_cur + 1'b1;
            end
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data        <= w_avg;
                out_ch          <= r_s1_ch;
                r_acc[r_s1_ch]  <= w_acc_new;
            end
        end
    end

endmodule

// File: tb/tb_mavg_tdm_filter.sv
// Randomized self-checking bench for mavg_tdm_filter against a sum-of-last-N reference model.
module tb_mavg_tdm_filter;

    localparam int W = 10, LOG2N_MAX = 5, CH = 4, CW = 2, LW = 3, NMAX = 32;
`ifdef MAVG_ROUND_EN
    localparam int IMP = 13;
`else
    localparam int IMP = 12;
`endif

    logic clk = 0, rst = 1, cfg_load = 0;
    logic [LW-1:0] cfg_log2n = '0;
    logic busy, in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [CW-1:0] in_ch = '0, out_ch;
    logic signed [W-1:0] in_data = '0, out_data;

    always #5 clk = ~clk;

    mavg_tdm_filter #(.W(W), .LOG2N_MAX(LOG2N_MAX), .CH(CH)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_log2n(cfg_log2n), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data)
    );

    int n_tests = 0, n_fail = 0;
    int m_log2n = LOG2N_MAX;
    int hist [CH][$];
    int exp_ch[$], exp_dat[$], cap_ch[$], cap_dat[$];

    function automatic int rand_x();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // Average of the last N samples on the channel; samples before a clear count as zero.
    function automatic int model_push(input int ch, input int x);
        int s = 0;
        int n = 1 << m_log2n;
        int sz;
        hist[ch].push_back(x);
        if (hist[ch].size() > NMAX) void'(hist[ch].pop_front());
        sz = hist[ch].size();
        for (int k = 0; k < n && k < sz; k++) s += hist[ch][sz-1-k];
`ifdef MAVG_ROUND_EN
        if (m_log2n > 0) s += 1 << (m_log2n - 1);
`endif
        return s >>> m_log2n;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < CH; c++) hist[c].delete();
        while (exp_dat.size() > cap_dat.size()) begin
            void'(exp_dat.pop_back());
            void'(exp_ch.pop_back());
        end
    endfunction

    task automatic cyc(input logic iv, input int ch, input int x, input logic ordy,
                       input logic cl, input int clv, input logic rs);
        @(negedge clk);
        rst = rs; cfg_load = cl; cfg_log2n = LW'(clv);
        in_valid = iv; in_ch = CW'(ch); in_data = W'(x); out_ready = ordy;
        #1;
        if (rs) begin
            m_log2n = LOG2N_MAX;
            model_clear();
        end else if (cl) begin
            m_log2n = (clv > LOG2N_MAX) ? LOG2N_MAX : clv;
            model_clear();
        end else begin
            if (out_valid && out_ready) begin
                cap_ch.push_back(int'(out_ch));
                cap_dat.push_back(int'(out_data));
            end
            if (in_valid && in_ready && ch < CH) begin
                exp_ch.push_back(ch);
                exp_dat.push_back(model_push(ch, x));
            end
        end
    endtask

    task automatic run_clear(output int nb, output bit rdy_seen);
        nb = 0; rdy_seen = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            if (busy !== 1'b1) break;
            nb++;
            if (in_ready !== 1'b0) rdy_seen = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        int nb; bit rs_seen;
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        n_tests++; if (out_ch !== '0) begin n_fail++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
        run_clear(nb, rs_seen);
        n_tests++; if (nb != 128) begin n_fail++; $display("FAIL rst_clear_len: got %0d want 128", nb); end
        n_tests++; if (rs_seen) begin n_fail++; $display("FAIL rst_clear_ready: in_ready seen 1 during clear, want 0"); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_run_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_impulse();
        int nb; bit rs_seen; int e;
        cyc(0, 0, 0, 1, 1, 3, 0);
        run_clear(nb, rs_seen);
        n_tests++; if (nb != 128) begin n_fail++; $display("FAIL imp_clear_len: got %0d want 128", nb); end
        for (int i = 0; i < 16; i++) cyc(1, 0, (i == 0) ? 100 : 0, 1, 0, 0, 0);
        idle(5);
        n_tests++; if (cap_dat.size() != 16) begin n_fail++; $display("FAIL imp_count: got %0d want 16", cap_dat.size()); end
        for (int i = 0; i < 16 && i < cap_dat.size(); i++) begin
            e = (i < 8) ? IMP : 0;
            n_tests++;
            if (cap_dat[i] !== e || cap_ch[i] !== 0) begin
                n_fail++; $display("FAIL imp_out%0d: got ch%0d %0d want ch0 %0d", i, cap_ch[i], cap_dat[i], e);
            end
        end
        exp_ch.delete(); exp_dat.delete(); cap_ch.delete(); cap_dat.delete();
    endtask

    task automatic test_step();
        int nb; bit rs_seen; int ec, ed;
        cyc(0, 0, 0, 1, 1, 2, 0);
        run_clear(nb, rs_seen);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < CH; c++) cyc(1, c, (c == 1) ? 80 : 0, 1, 0, 0, 0);
        idle(5);
        n_tests++; if (cap_dat.size() != 24) begin n_fail++; $display("FAIL step_count: got %0d want 24", cap_dat.size()); end
        for (int k = 0; k < 24 && k < cap_dat.size(); k++) begin
            ec = k % CH;
            ed = (ec == 1) ? ((k / CH < 3) ? 20 * (k / CH + 1) : 80) : 0;
            n_tests++;
            if (cap_dat[k] !== ed || cap_ch[k] !== ec) begin
                n_fail++; $display("FAIL step_out%0d: got ch%0d %0d want ch%0d %0d", k, cap_ch[k], cap_dat[k], ec, ed);
            end
        end
        exp_ch.delete(); exp_dat.delete(); cap_ch.delete(); cap_dat.delete();
    endtask

    task automatic test_forwarding();
        int nb; bit rs_seen; int lgs[2]; int e, a, ec, ac, ch;
        lgs[0] = 0; lgs[1] = 5;
        for (int t = 0; t < 2; t++) begin
            cyc(0, 0, 0, 1, 1, lgs[t], 0);
            run_clear(nb, rs_seen);
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < CH; c++) cyc(1, c, rand_x(), 1, 0, 0, 0);
            for (int k = 0; k < 4; k++) cyc(1, 2, rand_x(), 1, 0, 0, 0);
            for (int k = 0; k < 120; k++) begin
                ch = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CH-1)) : 2;
                cyc(1, ch, rand_x(), 1, 0, 0, 0);
            end
            idle(5);
            n_tests++;
            if (cap_dat.size() != exp_dat.size() || cap_dat.size() != 136) begin
                n_fail++; $display("FAIL fwd_count lg%0d: got %0d want %0d", lgs[t], cap_dat.size(), exp_dat.size());
            end
            while (cap_dat.size() > 0 && exp_dat.size() > 0) begin
                a = cap_dat.pop_front(); ac = cap_ch.pop_front();
                e = exp_dat.pop_front(); ec = exp_ch.pop_front();
                n_tests++;
                if (a !== e || ac !== ec) begin
                    n_fail++; $display("FAIL fwd_data lg%0d: got ch%0d %0d want ch%0d %0d", lgs[t], ac, a, ec, e);
                end
            end
            exp_ch.delete(); exp_dat.delete(); cap_ch.delete(); cap_dat.delete();
        end
    endtask

    task automatic test_backpressure();
        int nb; bit rs_seen; int acc_n = 0, e, a, ec, ac, pd, pc;
        bit ps = 0; logic ordy, iv;
        cyc(0, 0, 0, 1, 1, 6, 0);
        run_clear(nb, rs_seen);
        for (int k = 0; k < 40000 && acc_n < 10000; k++) begin
            iv   = ($urandom_range(0, 9) < 9);
            ordy = ($urandom_range(0, 9) >= 3);
            cyc(iv, $urandom_range(0, CH-1), rand_x(), ordy, 0, 0, 0);
            if (iv && in_ready) acc_n++;
            if (ps) begin
                n_tests++;
                if (out_valid !== 1'b1 || int'(out_data) !== pd || int'(out_ch) !== pc) begin
                    n_fail++; $display("FAIL bp_hold: got v%b ch%0d %0d want v1 ch%0d %0d", out_valid, out_ch, out_data, pc, pd);
                end
            end
            if (ordy) begin
                n_tests++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got %b want 1 with out_ready=1", in_ready); end
            end
            ps = out_valid && !out_ready; pd = int'(out_data); pc = int'(out_ch);
        end
        idle(6);
        n_tests++;
        if (cap_dat.size() != exp_dat.size() || cap_dat.size() != 10000) begin
            n_fail++; $display("FAIL bp_count: got %0d outputs, model %0d, accepted %0d want 10000", cap_dat.size(), exp_dat.size(), acc_n);
        end
        while (cap_dat.size() > 0 && exp_dat.size() > 0) begin
            a = cap_dat.pop_front(); ac = cap_ch.pop_front();
            e = exp_dat.pop_front(); ec = exp_ch.pop_front();
            n_tests++;
            if (a !== e || ac !== ec) begin
                n_fail++; $display("FAIL bp_data: got ch%0d %0d want ch%0d %0d", ac, a, ec, e);
            end
        end
        exp_ch.delete(); exp_dat.delete(); cap_ch.delete(); cap_dat.delete();
    endtask

    task automatic test_cfg_reload();
        int nb; bit rs_seen; int e, a, ec, ac, x;
        cyc(0, 0, 0, 1, 1, 3, 0);
        run_clear(nb, rs_seen);
        for (int k = 0; k < 40; k++) cyc(1, $urandom_range(0, CH-1), rand_x(), 1, 0, 0, 0);
        cyc(1, 1, rand_x(), 1, 1, 1, 0);
        while (cap_dat.size() > 0 && exp_dat.size() > 0) begin
            a = cap_dat.pop_front(); ac = cap_ch.pop_front();
            e = exp_dat.pop_front(); ec = exp_ch.pop_front();
            n_tests++;
            if (a !== e || ac !== ec) begin
                n_fail++; $display("FAIL cfg_pre_data: got ch%0d %0d want ch%0d %0d", ac, a, ec, e);
            end
        end
        n_tests++; if (exp_dat.size() != 0) begin n_fail++; $display("FAIL cfg_pre_count: %0d model outputs left, want 0", exp_dat.size()); end
        run_clear(nb, rs_seen);
        n_tests++; if (nb != 128) begin n_fail++; $display("FAIL cfg_busy_len: got %0d want 128", nb); end
        n_tests++; if (rs_seen) begin n_fail++; $display("FAIL cfg_busy_ready: in_ready seen 1 during clear, want 0"); end
        x = -(2 * int'($urandom_range(1, 200)) + 1);
        cyc(1, 3, x, 1, 0, 0, 0);
        idle(4);
`ifdef MAVG_ROUND_EN
        e = (x + 1) >>> 1;
`else
        e = x >>> 1;
`endif
        n_tests++;
        if (cap_dat.size() != 1 || cap_dat[0] !== e || cap_ch[0] !== 3) begin
            n_fail++; $display("FAIL cfg_first: got %0d outputs, first %0d want ch3 %0d", cap_dat.size(), (cap_dat.size() > 0) ? cap_dat[0] : 0, e);
        end
        exp_ch.delete(); exp_dat.delete(); cap_ch.delete(); cap_dat.delete();
    endtask

    task automatic test_rst_midstream();
        int nb, guard = 0, e, a, ec, ac, x; bit rs_seen;
        do begin
            cyc(1, $urandom_range(0, CH-1), rand_x(), 1, 0, 0, 0);
            guard++;
        end while (out_valid !== 1'b1 && guard < 20);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstm_pre_valid: got %b want 1 within 20 cycles", out_valid); end
        cyc(1, 0, rand_x(), 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_valid_drop: got %b want 0", out_valid); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstm_busy: got %b want 1", busy); end
        while (cap_dat.size() > 0 && exp_dat.size() > 0) begin
            a = cap_dat.pop_front(); ac = cap_ch.pop_front();
            e = exp_dat.pop_front(); ec = exp_ch.pop_front();
            n_tests++;
            if (a !== e || ac !== ec) begin
                n_fail++; $display("FAIL rstm_pre_data: got ch%0d %0d want ch%0d %0d", ac, a, ec, e);
            end
        end
        run_clear(nb, rs_seen);
        n_tests++; if (nb + 1 != 128) begin n_fail++; $display("FAIL rstm_busy_len: got %0d want 128", nb + 1); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstm_ready: got %b want 1", in_ready); end
        x = rand_x();
        cyc(1, 0, x, 1, 0, 0, 0);
        idle(4);
`ifdef MAVG_ROUND_EN
        e = (x + 16) >>> 5;
`else
        e = x >>> 5;
`endif
        n_tests++;
        if (cap_dat.size() != 1 || cap_dat[0] !== e || cap_ch[0] !== 0) begin
            n_fail++; $display("FAIL rstm_first: got %0d outputs, first %0d want ch0 %0d (x=%0d)", cap_dat.size(), (cap_dat.size() > 0) ? cap_dat[0] : 0, e, x);
        end
        exp_ch.delete(); exp_dat.delete(); cap_ch.delete(); cap_dat.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_forwarding();
        test_backpressure();
        test_cfg_reload();
        test_rst_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
